// File: rtl/rgb_frame_reader.sv
// rgb_frame_reader
// Reads the R, G and B frame memories in raster order once the demosaic
// engine has filled them and emits one packed RGB pixel per valid/ready beat.
// Border pixels, which the demosaic engine never writes, are handled per
// BORDER_MODE: 0 = raw memory, 1 = forced to black, 2 = coordinate clamped
// into the interior.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   start              one-cycle frame request (accepted in IDLE/DONE only)
//   addr_r/g/b         registered memory read address {y,x}
//   rdata_r/g/b        combinational memory read data for the held address
//   out_valid/ready    output stream handshake
//   out_data           {R,G,B}
//   out_sof/eol/eof    start of frame, end of line, end of frame qualifiers
//   busy, done         frame in progress / frame fully delivered
module rgb_frame_reader #(
    parameter int IMG_W       = 128,
    parameter int IMG_H       = 128,
    parameter int BORDER_MODE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [13:0] addr_r,
    input  logic [7:0]  rdata_r,
    output logic [13:0] addr_g,
    input  logic [7:0]  rdata_g,
    output logic [13:0] addr_b,
    input  logic [7:0]  rdata_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_data,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_eof,
    output logic        busy,
    output logic        done
);

    localparam logic [6:0] X_LAST = 7'(IMG_W - 1);
    localparam logic [6:0] Y_LAST = 7'(IMG_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  fx_q, fx_d;
    logic [6:0]  fy_q, fy_d;
    logic [13:0] addr_q, addr_d;
    logic [23:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic        eol_q, eol_d;
    logic        eof_q, eof_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        load_s;
    logic        border_s;
    logic        last_s;

    // Memory address for a logical pixel; mode 2 clamps into the interior so
    // border pixels replicate their nearest written neighbour.
    function automatic logic [13:0] fetch_addr(input logic [6:0] x, input logic [6:0] y);
        logic [6:0] ax;
        logic [6:0] ay;
        ax = x;
        ay = y;
        if (BORDER_MODE == 2) begin
            if (x < 7'd1) begin
                ax = 7'd1;
            end else if (x > X_LAST - 7'd1) begin
                ax = X_LAST - 7'd1;
            end else begin
                ax = x;
            end
            if (y < 7'd1) begin
                ay = 7'd1;
            end else if (y > Y_LAST - 7'd1) begin
                ay = Y_LAST - 7'd1;
            end else begin
                ay = y;
            end
        end else begin
            ax = x;
            ay = y;
        end
        return {ay, ax};
    endfunction

    // Output register may be refilled whenever it is empty or being drained.
    assign load_s   = !valid_q || out_ready;
    assign border_s = (fx_q == 7'd0) || (fx_q == X_LAST) || (fy_q == 7'd0) || (fy_q == Y_LAST);
    assign last_s   = (fx_q == X_LAST) && (fy_q == Y_LAST);

    // Next-state logic for the frame sequencer, pointer and output register.
    always_comb begin
        state_d = state_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        sof_d   = sof_q;
        eol_d   = eol_q;
        eof_d   = eof_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    fx_d    = 7'd0;
                    fy_d    = 7'd0;
                    addr_d  = fetch_addr(7'd0, 7'd0);
                end else begin
                    state_d = state_q;
                end
            end
            ST_STREAM: begin
                if (load_s) begin
                    if ((BORDER_MODE == 1) && border_s) begin
                        data_d = 24'h000000;
                    end else begin
                        data_d = {rdata_r, rdata_g, rdata_b};
                    end
                    valid_d = 1'b1;
                    sof_d   = (fx_q == 7'd0) && (fy_q == 7'd0);
                    eol_d   = (fx_q == X_LAST);
                    eof_d   = last_s;
                    // The pointer parks on the final pixel; DRAIN only waits
                    // for the sink to take it.
                    if (last_s) begin
                        state_d = ST_DRAIN;
                    end else if (fx_q == X_LAST) begin
                        fx_d   = 7'd0;
                        fy_d   = fy_q + 7'd1;
                        addr_d = fetch_addr(7'd0, fy_q + 7'd1);
                    end else begin
                        fx_d   = fx_q + 7'd1;
                        addr_d = fetch_addr(fx_q + 7'd1, fy_q);
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            fx_q    <= 7'd0;
            fy_q    <= 7'd0;
            addr_q  <= 14'd0;
            data_q  <= 24'h000000;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign addr_r    = addr_q;
    assign addr_g    = addr_q;
    assign addr_b    = addr_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sof   = sof_q;
    assign out_eol   = eol_q;
    assign out_eof   = eof_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rgb_frame_reader.sv
// Bench for rgb_frame_reader: three instances (BORDER_MODE 0, 1, 2) share
// clock, reset, start and out_ready, each reading its own memory model
// R=x, G=y, B=x^y. Every accepted beat is compared with a pixel computed
// from frame coordinates.
module tb_rgb_frame_reader;

    localparam int W    = 128;
    localparam int H    = 128;
    localparam int NPIX = W * H;

    logic        clk;
    logic        reset;
    logic        start;
    logic        out_ready;

    logic [13:0] addr_r_s [3];
    logic [13:0] addr_g_s [3];
    logic [13:0] addr_b_s [3];
    logic [7:0]  rd_r_s   [3];
    logic [7:0]  rd_g_s   [3];
    logic [7:0]  rd_b_s   [3];
    logic [23:0] data_s   [3];
    logic        valid_s  [3];
    logic        sof_s    [3];
    logic        eol_s    [3];
    logic        eof_s    [3];
    logic        busy_s   [3];
    logic        done_s   [3];

    int vectors     = 0;
    int miscompares = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rgb_frame_reader #(.IMG_W(W), .IMG_H(H), .BORDER_MODE(g)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
            .addr_r    (addr_r_s[g]),
            .rdata_r   (rd_r_s[g]),
            .addr_g    (addr_g_s[g]),
            .rdata_g   (rd_g_s[g]),
            .addr_b    (addr_b_s[g]),
            .rdata_b   (rd_b_s[g]),
            .out_valid (valid_s[g]),
            .out_ready (out_ready),
            .out_data  (data_s[g]),
            .out_sof   (sof_s[g]),
            .out_eol   (eol_s[g]),
            .out_eof   (eof_s[g]),
            .busy      (busy_s[g]),
            .done      (done_s[g])
        );
        assign rd_r_s[g] = {1'b0, addr_r_s[g][6:0]};
        assign rd_g_s[g] = {1'b0, addr_g_s[g][13:7]};
        assign rd_b_s[g] = {1'b0, addr_b_s[g][6:0] ^ addr_b_s[g][13:7]};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixel the sink should see at frame coordinate (x,y) for a border mode.
    function automatic logic [23:0] exp_pix(input int mode, input int x, input int y);
        int mx;
        int my;
        if (mode == 1 && (x == 0 || x == W - 1 || y == 0 || y == H - 1)) return 24'h000000;
        mx = x;
        my = y;
        if (mode == 2) begin
            mx = (x < 1) ? 1 : ((x > W - 2) ? W - 2 : x);
            my = (y < 1) ? 1 : ((y > H - 2) ? H - 2 : y);
        end
        return {8'(mx), 8'(my), 8'(mx ^ my)};
    endfunction

    task automatic check_zero(input string tag);
        for (int g = 0; g < 3; g++) begin
            chk({tag, "_valid"}, 32'(valid_s[g]), 32'd0);
            chk({tag, "_busy"},  32'(busy_s[g]),  32'd0);
            chk({tag, "_done"},  32'(done_s[g]),  32'd0);
            chk({tag, "_flags"}, 32'({sof_s[g], eol_s[g], eof_s[g]}), 32'd0);
            chk({tag, "_data"},  32'(data_s[g]),  32'd0);
            chk({tag, "_addr"},  32'({addr_r_s[g], addr_g_s[g], addr_b_s[g]}), 32'd0);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk("start_busy",  32'(busy_s[g]),  32'd1);
            chk("start_valid", 32'(valid_s[g]), 32'd0);
            chk("start_done",  32'(done_s[g]),  32'd0);
        end
    endtask

    // Streams one frame with out_ready high pct% of cycles, scoring every
    // accepted beat. start is pulsed once when beat start_at is on display;
    // reset is asserted once beat abort_at is reached.
    task automatic run_frame(input int pct, input bit strict_timing,
                             input int start_at, input int abort_at);
        int          k          = 0;
        int          cycles     = 0;
        int          first_v    = -1;
        int          last_acc   = -1;
        bit          prev_stall = 1'b0;
        bit          aborted    = 1'b0;
        logic [26:0] held [3];
        int          x;
        int          y;
        int          ea;
        while (k < NPIX && cycles < 4 * NPIX) begin
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                check_zero("abort");
                @(negedge clk);
                reset   = 1'b0;
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
            if (prev_stall) begin
                for (int g = 0; g < 3; g++) begin
                    chk("stall_valid", 32'(valid_s[g]), 32'd1);
                    chk("stall_hold", 32'({sof_s[g], eol_s[g], eof_s[g], data_s[g]}), 32'(held[g]));
                end
            end
            if (busy_s[0]) begin
                ea = (valid_s[0] === 1'b1) ? ((k + 1 < NPIX) ? k + 1 : NPIX - 1) : k;
                chk("addr_m0", 32'(addr_r_s[0]), 32'(((ea / W) << 7) | (ea % W)));
                chk("addr_m1", 32'(addr_g_s[1]), 32'(((ea / W) << 7) | (ea % W)));
                x = int'(addr_r_s[2][6:0]);
                y = int'(addr_r_s[2][13:7]);
                chk("addr_clamp", 32'(x >= 1 && x <= W - 2 && y >= 1 && y <= H - 2), 32'd1);
            end
            start     = (k == start_at && valid_s[0] === 1'b1) ? 1'b1 : 1'b0;
            out_ready = ($urandom_range(99) < pct) ? 1'b1 : 1'b0;
            if (valid_s[0] === 1'b1 && first_v < 0) first_v = cycles;
            if (valid_s[0] === 1'b1 && out_ready) begin
                x = k % W;
                y = k / W;
                for (int g = 0; g < 3; g++) begin
                    chk("beat_valid", 32'(valid_s[g]), 32'd1);
                    chk("beat_data", 32'(data_s[g]), 32'(exp_pix(g, x, y)));
                    chk("beat_sof", 32'(sof_s[g]), 32'(k == 0));
                    chk("beat_eol", 32'(eol_s[g]), 32'(x == W - 1));
                    chk("beat_eof", 32'(eof_s[g]), 32'(k == NPIX - 1));
                end
                k++;
                last_acc = cycles;
            end
            prev_stall = (valid_s[0] === 1'b1) && !out_ready;
            for (int g = 0; g < 3; g++) held[g] = {sof_s[g], eol_s[g], eof_s[g], data_s[g]};
        end
        start = 1'b0;
        if (!aborted) begin
            chk("beat_count", 32'(k), 32'(NPIX));
            if (strict_timing) begin
                chk("first_latency", 32'(first_v), 32'd1);
                chk("consecutive", 32'(last_acc - first_v + 1), 32'(NPIX));
            end
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                chk("end_done",  32'(done_s[g]),  32'd1);
                chk("end_busy",  32'(busy_s[g]),  32'd0);
                chk("end_valid", 32'(valid_s[g]), 32'd0);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_zero("idle");
        end

        // Full frame, sink always ready.
        do_start();
        run_frame(100, 1'b1, -1, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                chk("done_hold", 32'(done_s[g]), 32'd1);
                chk("done_idle_valid", 32'(valid_s[g]), 32'd0);
            end
        end

        // Random backpressure, with a start pulse mid-stream that must be ignored.
        do_start();
        run_frame(70, 1'b0, 3000, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                chk("no_extra_frame_valid", 32'(valid_s[g]), 32'd0);
                chk("no_extra_frame_busy",  32'(busy_s[g]),  32'd0);
            end
        end

        // Reset during the frame, then a clean frame from (0,0).
        do_start();
        run_frame(100, 1'b0, -1, 500);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero("post_abort");
        end
        do_start();
        run_frame(100, 1'b1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rgb_frame_reader.md
Name: rgb_frame_reader

Overview:
- Read-back end of the demosaic datapath.
- After the demosaic engine has written the three 128x128 planes (R, G, B), this block reads all three memories in raster order and emits one packed 24-bit RGB pixel per handshake on a valid/ready stream.
- Sits between the R/G/B frame memories and the display/DMA sink. It owns the memory read addresses while busy; the top level muxes them against the demosaic engine.
- Handles the 1-pixel frame border, which the demosaic engine never writes, according to BORDER_MODE.

Parameters:
- IMG_W, 128, pixels per line (2..128); x occupies addr[6:0].
- IMG_H, 128, lines per frame (2..128); y occupies addr[13:7].
- BORDER_MODE, 0, border handling:
  - 0 = raw memory contents.
  - 1 = force the pixel to 24'h000000.
  - 2 = clamp the coordinate to the interior, x in 1..IMG_W-2 and y in 1..IMG_H-2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to read one frame; ignored unless the block is idle or done.
- addr_r  out  14  R memory read address {y,x}.
- rdata_r  in  8  R memory data for addr_r as held in the current cycle (combinational read).
- addr_g  out  14  G memory read address.
- rdata_g  in  8  G data.
- addr_b  out  14  B memory read address.
- rdata_b  in  8  B data.
- out_valid  out  1  out_data holds a pixel.
- out_ready  in  1  sink accepts the pixel when out_valid&&out_ready at a rising edge.
- out_data  out  24  {R[23:16],G[15:8],B[7:0]}.
- out_sof  out  1  qualifies pixel (0,0).
- out_eol  out  1  qualifies x==IMG_W-1.
- out_eof  out  1  qualifies (IMG_W-1,IMG_H-1).
- busy  out  1  high from start accept until the last pixel is accepted.
- done  out  1  high after the last pixel is accepted; held until the next accepted start.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high. On reset, all outputs are 0 (addresses 0, out_data 0, flags 0, busy 0, done 0), the state is IDLE and the pixel pointer (fx,fy)=(0,0). Reset mid-frame abandons the frame with no further output.
- The fetch pointer (fx,fy) is the logical pixel. addr_r=addr_g=addr_b={ay,ax} are registered:
  - BORDER_MODE 2: ax=clamp(fx,1,IMG_W-2), ay=clamp(fy,1,IMG_H-2).
  - Otherwise: ax=fx, ay=fy.
- States:
  - IDLE: on start, go to STREAM; set busy=1, done=0, pointer (0,0); addresses are loaded the same edge.
  - STREAM: load condition L = !out_valid || out_ready. On L, capture the output register:
    - out_data = {rdata_r,rdata_g,rdata_b}, or 0 if BORDER_MODE==1 and fx∈{0,IMG_W-1} or fy∈{0,IMG_H-1}.
    - out_valid=1; sof/eol/eof from (fx,fy).
    - Advance the pointer: fx+1; at fx==IMG_W-1, fx=0 and fy+1. Addresses are updated the same edge.
    - Loading pixel (IMG_W-1,IMG_H-1) moves to DRAIN; the pointer does not advance past it.
  - DRAIN: no new loads. When out_valid&&out_ready: out_valid=0, busy=0, done=1, go to DONE.
  - DONE: done stays 1. start is accepted as in IDLE.
- start in STREAM or DRAIN is ignored.
- Handshake rules:
  - While out_valid&&!out_ready, out_data and all flags are held stable.
  - out_valid only falls after acceptance.
  - A fresh pixel may be loaded on the same edge the previous one is accepted, so there are no bubbles.
- Latency and throughput:
  - start sampled at edge 0 → addresses valid after edge 0 → out_valid high after edge 1 with pixel (0,0).
  - With out_ready held at 1: exactly IMG_W*IMG_H consecutive valid cycles; done rises on the edge that accepts the last pixel.
- Addresses are not reset between frames except by start. The address outputs hold their last value in DONE.

Test Plan:
- Reset then idle: out_valid, busy and done stay 0 for 20 cycles; start=0; all addresses 0.
- Full frame, BORDER_MODE 0, out_ready=1, memories R=x, G=y, B=x^y:
  - first out_valid 2 edges after start, with 24'h000000 and sof=1;
  - 16384 consecutive beats; pixel (5,3) = 24'h050306;
  - eol on every 128th beat; eof only on the last beat;
  - done=1 on the following cycle.
- Backpressure: out_ready toggles with a pseudo-random pattern → out_data stable while stalled; no pixel dropped or duplicated; the beat sequence is identical to the previous test.
- BORDER_MODE 1: border pixels (0,0), (127,5) and (64,127) output 0; interior pixel (1,1) = 24'h010100.
- BORDER_MODE 2: pixel (0,0) outputs memory(1,1)=24'h010100; (127,127) outputs memory(126,126)=24'h7E7E00; addr_r never has x or y equal to 0 or 127.
- Robustness:
  - start pulsed mid-STREAM → ignored, frame count unchanged.
  - reset asserted at beat 500 → all outputs 0 immediately.
  - a subsequent start then streams a complete frame from (0,0).
